// File: rtl/vga_fb_fetch_if.sv
// Pixel-pop port and single-byte SRAM read-request port of the framebuffer fetch stage.
interface vga_fb_fetch_if;
    logic        pix_rd_in;
    logic [7:0]  pix_data_out;
    logic        pix_valid_out;
    logic        sram_trig_out;
    logic        sram_rw_out;
    logic [18:0] sram_addr_out;
    logic [7:0]  sram_r_data_in;

    modport master (
        input  pix_rd_in,
        input  sram_r_data_in,
        output pix_data_out,
        output pix_valid_out,
        output sram_trig_out,
        output sram_rw_out,
        output sram_addr_out
    );

    modport slave (
        output pix_rd_in,
        output sram_r_data_in,
        input  pix_data_out,
        input  pix_valid_out,
        input  sram_trig_out,
        input  sram_rw_out,
        input  sram_addr_out
    );
endinterface

// File: rtl/vga_fb_fetch.sv
// Framebuffer fetch: walks the frame one byte read at a time and buffers pixels in a small FIFO
// that the VGA colour stage pops once per active pixel.
module vga_fb_fetch #(
    parameter logic [18:0] BASE_ADDR  = 19'h00000,
    parameter int unsigned FRAME_PIX  = 307200,
    parameter int unsigned READ_LAT   = 3,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           frame_start_in,
    output logic           underflow_out,
    output logic           frame_done_out,
    vga_fb_fetch_if.master fetch_bus
);
    localparam int unsigned PixW = $clog2(FRAME_PIX + 1);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [PixW-1:0] PixLast  = PixW'(FRAME_PIX);
    localparam logic [PtrW:0]   FifoFull = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [2:0]      LatInit  = 3'(READ_LAT - 1);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StStore, StDrain} state_e;

    state_e          state_q;
    logic [2:0]      lat_q;
    logic [PixW-1:0] pix_cnt_q;
    logic            trig_q;
    logic [18:0]     addr_q;
    logic            underflow_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   cnt_q, cnt_d;
    logic            push, pop;
    logic [18:0]     fetch_addr;

    assign fetch_addr = BASE_ADDR + 19'(pix_cnt_q);

    // frame_start_in wins over both FIFO ports
    always_comb begin
        push = (state_q == StStore) && !frame_start_in;
        pop  = fetch_bus.pix_rd_in && (cnt_q != '0) && !frame_start_in;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PtrW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (PtrW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            lat_q       <= '0;
            pix_cnt_q   <= '0;
            trig_q      <= 1'b0;
            addr_q      <= BASE_ADDR;
            underflow_q <= 1'b0;
        end else if (frame_start_in) begin
            pix_cnt_q   <= '0;
            underflow_q <= 1'b0;
            trig_q      <= 1'b0;
            // An in-flight read must still be waited out before the next trig
            if (state_q == StWait || state_q == StDrain) begin
                state_q <= StDrain;
            end else begin
                state_q <= StIdle;
            end
        end else begin
            trig_q <= 1'b0;
            if (fetch_bus.pix_rd_in && (cnt_q == '0)) begin
                underflow_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if ((pix_cnt_q < PixLast) && (cnt_q < FifoFull)) begin
                        state_q <= StIssue;
                        trig_q  <= 1'b1;
                        addr_q  <= fetch_addr;
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                    lat_q   <= LatInit;
                end
                StWait: begin
                    if (lat_q == 3'd0) state_q <= StStore;
                    else               lat_q   <= lat_q - 3'd1;
                end
                StStore: begin
                    pix_cnt_q <= pix_cnt_q + PixW'(1);
                    state_q   <= StIdle;
                end
                StDrain: begin
                    if (lat_q == 3'd0) state_q <= StIdle;
                    else               lat_q   <= lat_q - 3'd1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || frame_start_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= fetch_bus.sram_r_data_in;
    end

    assign fetch_bus.sram_trig_out = trig_q;
    assign fetch_bus.sram_rw_out   = 1'b1;
    assign fetch_bus.sram_addr_out = addr_q;
    assign fetch_bus.pix_valid_out = (cnt_q != '0);
    assign fetch_bus.pix_data_out  = (cnt_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign underflow_out           = underflow_q;
    assign frame_done_out          = (pix_cnt_q == PixLast);
endmodule

// File: tb/tb_vga_fb_fetch.sv
// Bench for vga_fb_fetch: SRAM latency model, address/pixel scoreboards and directed frame scenarios.
module tb_vga_fb_fetch;
    localparam int unsigned RdLat = 3;
    localparam logic [18:0] Base0 = 19'h00000;
    localparam logic [18:0] Base1 = 19'h7FFF8;

    logic clk = 1'b0;
    logic rst, fs0, fs1;
    logic uf0, done0, uf1, done1;

    always #5 clk = ~clk;

    vga_fb_fetch_if bus0 ();
    vga_fb_fetch_if bus1 ();

    vga_fb_fetch #(
        .BASE_ADDR(Base0), .FRAME_PIX(307200), .READ_LAT(RdLat), .FIFO_DEPTH(16)
    ) dut0 (
        .clk(clk), .rst(rst), .frame_start_in(fs0), .underflow_out(uf0),
        .frame_done_out(done0), .fetch_bus(bus0)
    );

    vga_fb_fetch #(
        .BASE_ADDR(Base1), .FRAME_PIX(20), .READ_LAT(RdLat), .FIFO_DEPTH(16)
    ) dut1 (
        .clk(clk), .rst(rst), .frame_start_in(fs1), .underflow_out(uf1),
        .frame_done_out(done1), .fetch_bus(bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input bit ok, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // SRAM controller model: byte = addr[7:0]^key, valid READ_LAT clks after trig, then held
    logic [2:0]  m0_cnt, m1_cnt;
    logic [18:0] m0_addr, m1_addr;
    logic [7:0]  key = 8'h00;

    always @(posedge clk) begin
        if (!rst) begin
            m0_cnt <= 3'd0; m0_addr <= '0; bus0.sram_r_data_in <= 8'h00;
            m1_cnt <= 3'd0; m1_addr <= '0; bus1.sram_r_data_in <= 8'h00;
        end else begin
            if (bus0.sram_trig_out) begin
                m0_cnt <= 3'(RdLat); m0_addr <= bus0.sram_addr_out;
            end else if (m0_cnt != 3'd0) m0_cnt <= m0_cnt - 3'd1;
            if (m0_cnt == 3'd1) bus0.sram_r_data_in <= m0_addr[7:0] ^ key;
            if (bus1.sram_trig_out) begin
                m1_cnt <= 3'(RdLat); m1_addr <= bus1.sram_addr_out;
            end else if (m1_cnt != 3'd0) m1_cnt <= m1_cnt - 3'd1;
            if (m1_cnt == 3'd1) bus1.sram_r_data_in <= m1_addr[7:0];
        end
    end

    // Monitor: trig address/spacing and popped pixel scoreboards
    logic [18:0] exp_a0 = Base0, exp_a1 = Base1;
    logic [7:0]  pq0[$], pq1[$];
    logic [7:0]  e0, e1;
    int ncyc = 0, last_t0 = -100, last_t1 = -100;
    int trigs0 = 0, trigs1 = 0, pops0 = 0, pops1 = 0;
    bit done1_seen = 1'b0;
    int pops1_at_done = -1;

    always @(negedge clk) begin
        ncyc++;
        if (bus0.sram_trig_out === 1'b1) begin
            chk("trig0_addr", bus0.sram_addr_out == exp_a0, int'(bus0.sram_addr_out), int'(exp_a0));
            chk("trig0_gap", (ncyc - last_t0) >= int'(RdLat + 1), ncyc - last_t0, RdLat + 1);
            chk("trig0_rw", bus0.sram_rw_out === 1'b1, int'(bus0.sram_rw_out), 1);
            last_t0 = ncyc; trigs0++; exp_a0 = exp_a0 + 19'd1;
        end
        if (fs0) exp_a0 = Base0;
        if (!fs0 && bus0.pix_rd_in && bus0.pix_valid_out === 1'b1) begin
            if (pq0.size() == 0) chk("pop0_unexpected", 1'b0, int'(bus0.pix_data_out), 0);
            else begin
                e0 = pq0.pop_front();
                chk("pop0_data", bus0.pix_data_out == e0, int'(bus0.pix_data_out), int'(e0));
            end
            pops0++;
        end
        if (bus1.sram_trig_out === 1'b1) begin
            chk("trig1_addr", bus1.sram_addr_out == exp_a1, int'(bus1.sram_addr_out), int'(exp_a1));
            chk("trig1_gap", (ncyc - last_t1) >= int'(RdLat + 1), ncyc - last_t1, RdLat + 1);
            last_t1 = ncyc; trigs1++; exp_a1 = exp_a1 + 19'd1;
        end
        if (fs1) exp_a1 = Base1;
        if (done1 === 1'b1 && !done1_seen) begin
            done1_seen = 1'b1; pops1_at_done = pops1;
        end
        if (!fs1 && bus1.pix_rd_in && bus1.pix_valid_out === 1'b1) begin
            if (pq1.size() == 0) chk("pop1_unexpected", 1'b0, int'(bus1.pix_data_out), 0);
            else begin
                e1 = pq1.pop_front();
                chk("pop1_data", bus1.pix_data_out == e1, int'(bus1.pix_data_out), int'(e1));
            end
            pops1++;
        end
    end

    int trig_k, valid_k, base_t, base_p, snap;
    logic [7:0]  valid_d;
    logic [18:0] a;
    bit stale;

    initial begin
        rst = 1'b0; fs0 = 1'b0; fs1 = 1'b0;
        bus0.pix_rd_in = 1'b0; bus1.pix_rd_in = 1'b0;

        // T1 reset
        repeat (3) begin
            step();
            chk("rst_trig", bus0.sram_trig_out === 1'b0, int'(bus0.sram_trig_out), 0);
        end
        @(negedge clk);
        chk("rst_valid", bus0.pix_valid_out === 1'b0, int'(bus0.pix_valid_out), 0);
        chk("rst_data", bus0.pix_data_out === 8'h00, int'(bus0.pix_data_out), 0);
        chk("rst_uf", uf0 === 1'b0, int'(uf0), 0);
        chk("rst_done", done0 === 1'b0, int'(done0), 0);
        chk("rst_addr0", bus0.sram_addr_out === Base0, int'(bus0.sram_addr_out), int'(Base0));
        chk("rst_addr1", bus1.sram_addr_out === Base1, int'(bus1.sram_addr_out), int'(Base1));
        chk("rst_rw", bus0.sram_rw_out === 1'b1, int'(bus0.sram_rw_out), 1);
        step();

        // T2 first fetch: frame_start at clk0, trig seen at clk2, pixel valid at clk7
        key = 8'hA5; rst = 1'b1; fs0 = 1'b1;
        step();
        fs0 = 1'b0;
        trig_k = -1; valid_k = -1; valid_d = 8'h00;
        for (int k = 0; k < 20 && valid_k < 0; k++) begin
            @(negedge clk);
            if (bus0.sram_trig_out === 1'b1 && trig_k < 0) trig_k = k;
            if (bus0.pix_valid_out === 1'b1) begin valid_k = k; valid_d = bus0.pix_data_out; end
        end
        chk("t2_trig_time", trig_k == 1, trig_k, 1);
        chk("t2_valid_time", valid_k == 6, valid_k, 6);
        chk("t2_data", valid_d == 8'hA5, int'(valid_d), 8'hA5);
        step(); step();
        key = 8'h00; fs0 = 1'b1;   // second read is now in WAIT
        step();
        fs0 = 1'b0;

        // T3 fill to 16, no trig while full, pop 00..0F in order
        base_t = trigs0;
        repeat (120) step();
        chk("t3_fill_trigs", trigs0 - base_t == 16, trigs0 - base_t, 16);
        snap = trigs0;
        repeat (100) step();
        chk("t3_no_trig_full", trigs0 == snap, trigs0 - snap, 0);
        chk("t3_head", bus0.pix_valid_out === 1'b1 && bus0.pix_data_out == 8'h00,
            int'(bus0.pix_data_out), 0);
        for (int i = 0; i < 16; i++) pq0.push_back(8'(i));
        base_p = pops0;
        bus0.pix_rd_in = 1'b1;
        repeat (16) step();
        bus0.pix_rd_in = 1'b0;
        @(negedge clk);
        chk("t3_pops", pops0 - base_p == 16, pops0 - base_p, 16);
        chk("t3_queue_empty", pq0.size() == 0, pq0.size(), 0);
        repeat (150) step();

        // T4 underflow: flush, then pop while empty
        fs0 = 1'b1;
        step();
        fs0 = 1'b0; bus0.pix_rd_in = 1'b1;
        step();
        bus0.pix_rd_in = 1'b0;
        @(negedge clk);
        chk("t4_uf_set", uf0 === 1'b1, int'(uf0), 1);
        chk("t4_empty_data", bus0.pix_data_out === 8'h00 && bus0.pix_valid_out === 1'b0,
            int'(bus0.pix_data_out), 0);
        repeat (12) step();
        chk("t4_uf_sticky", uf0 === 1'b1, int'(uf0), 1);
        chk("t4_refill", bus0.pix_valid_out === 1'b1, int'(bus0.pix_valid_out), 1);

        // T5 abort one clk after a trig; also clears the underflow flag
        trig_k = -1;
        for (int k = 0; k < 30 && trig_k < 0; k++) begin
            @(negedge clk);
            if (bus0.sram_trig_out === 1'b1) trig_k = k;
        end
        chk("t5_found_trig", trig_k >= 0, trig_k, 0);
        step();
        fs0 = 1'b1;
        step();
        fs0 = 1'b0;
        trig_k = -1; stale = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j == 0) begin
                chk("t5_flushed", bus0.pix_valid_out === 1'b0, int'(bus0.pix_valid_out), 0);
                chk("t5_uf_clear", uf0 === 1'b0, int'(uf0), 0);
            end
            if (bus0.sram_trig_out === 1'b1 && trig_k < 0) trig_k = j;
            if (j < 9 && bus0.pix_valid_out !== 1'b0) stale = 1'b1;
            if (j == 9) chk("t5_first_pixel", bus0.pix_valid_out === 1'b1 &&
                            bus0.pix_data_out == 8'h00, int'(bus0.pix_valid_out), 1);
        end
        chk("t5_no_stale_write", !stale, int'(stale), 0);
        chk("t5_trig_after_drain", trig_k == 4, trig_k, 4);

        // T6 short frame with address wrap, continuous consumer
        chk("t6_not_done", done1 === 1'b0, int'(done1), 0);
        for (int i = 0; i < 20; i++) begin
            a = Base1 + 19'(i);
            pq1.push_back(a[7:0]);
        end
        fs1 = 1'b1;
        step();
        fs1 = 1'b0; bus1.pix_rd_in = 1'b1;
        base_t = trigs1; base_p = pops1;
        for (int k = 0; k < 400 && !done1_seen; k++) step();
        chk("t6_done_seen", done1_seen, int'(done1_seen), 1);
        chk("t6_done_after_20th", pops1_at_done - base_p == 19, pops1_at_done - base_p, 19);
        repeat (60) step();
        chk("t6_trigs", trigs1 - base_t == 20, trigs1 - base_t, 20);
        chk("t6_pops", pops1 - base_p == 20, pops1 - base_p, 20);
        chk("t6_done_hold", done1 === 1'b1, int'(done1), 1);
        chk("t6_queue_empty", pq1.size() == 0, pq1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
